// File: rtl/gf2_poly_div_16.sv
// Bit-serial GF(2) polynomial divider: (2*DW-1)-bit dividend by DW-bit divisor, one quotient bit per cycle.
// Optional GF2DIV_EARLY_EXIT_EN starts the long division at the dividend MSB instead of bit NW-1.
module gf2_poly_div_16 #(
    parameter int unsigned DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-2:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-2:0]   quotient,
    output logic [DW-2:0]     remainder,
    output logic              div_by_zero
);

    localparam int unsigned NW = 2 * DW - 1;
    localparam int unsigned PW = $clog2(NW);

    typedef enum logic [1:0] {
        IDLE,
        DEG,
        DIV,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   r_q, r_d;
    logic [NW-1:0]   q_q, q_d;
    logic [DW-1:0]   d_q, d_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic [PW-1:0]   deg_q, deg_d;
    logic [NW-1:0]   quotient_q, quotient_d;
    logic [DW-2:0]   remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            out_valid_q, out_valid_d;

    logic [PW-1:0]   deg_enc;
    logic [PW-1:0]   shamt;
    logic [NW-1:0]   d_shifted;
`ifdef GF2DIV_EARLY_EXIT_EN
    logic [PW-1:0]   msb_r;
`endif

    always_comb begin
        deg_enc = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (d_q[i]) deg_enc = PW'(i);
        end
    end

`ifdef GF2DIV_EARLY_EXIT_EN
    always_comb begin
        msb_r = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (r_q[i]) msb_r = PW'(i);
        end
    end
`endif

    // Divisor aligned so its leading term sits under the current dividend bit.
    assign shamt     = pos_q - deg_q;
    assign d_shifted = NW'(d_q) << shamt;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        pos_d       = pos_q;
        deg_d       = deg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_d     = dividend;
                    d_d     = divisor;
                    q_d     = '0;
                    state_d = DEG;
                end
            end

            DEG: begin
                if (d_q == '0) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    deg_d = deg_enc;
`ifdef GF2DIV_EARLY_EXIT_EN
                    if (r_q == '0 || msb_r < deg_enc) begin
                        quotient_d  = '0;
                        remainder_d = r_q[DW-2:0];
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        pos_d   = msb_r;
                        state_d = DIV;
                    end
`else
                    pos_d   = PW'(NW - 1);
                    state_d = DIV;
`endif
                end
            end

            DIV: begin
                if (r_q[pos_q]) begin
                    r_d        = r_q ^ d_shifted;
                    q_d[shamt] = 1'b1;
                end
                if (pos_q == deg_q) begin
                    quotient_d  = q_d;
                    remainder_d = r_d[DW-2:0];
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            pos_q       <= '0;
            deg_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            pos_q       <= pos_d;
            deg_q       <= deg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf2_poly_div_16.sv
// Scoreboard bench for gf2_poly_div_16: expected results queued at drive time, popped on out_valid.
module tb_gf2_poly_div_16;

    localparam int DW = 16;
    localparam int NW = 2 * DW - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-2:0] remainder;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NW-1:0] q;
        logic [DW-2:0] r;
        logic          dbz;
        int            lat;
    } exp_t;

    exp_t sb[$];

    gf2_poly_div_16 #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [NW-1:0] n, input logic [DW-1:0] dv);
        exp_t e;
        logic [NW-1:0] r;
        int deg;
        int m;
        e.q = '0;
        e.r = '0;
        e.dbz = 1'b0;
        if (dv == '0) begin
            e.dbz = 1'b1;
            e.lat = 1;
            return e;
        end
        deg = 0;
        for (int i = 0; i < DW; i++) if (dv[i]) deg = i;
        m = -1;
        for (int i = 0; i < NW; i++) if (n[i]) m = i;
        r = n;
        for (int i = NW - 1; i >= deg; i--) begin
            if (r[i]) begin
                r = r ^ (NW'(dv) << (i - deg));
                e.q[i - deg] = 1'b1;
            end
        end
        e.r = r[DW-2:0];
`ifdef GF2DIV_EARLY_EXIT_EN
        e.lat = (m < deg) ? 1 : 1 + (m - deg + 1);
`else
        e.lat = 1 + (NW - deg);
`endif
        return e;
    endfunction

    function automatic logic [NW+DW-1:0] clmul(input logic [NW-1:0] a, input logic [DW-1:0] b);
        logic [NW+DW-1:0] p;
        p = '0;
        for (int i = 0; i < DW; i++) if (b[i]) p = p ^ ((NW + DW)'(a) << i);
        return p;
    endfunction

    // Present a transaction and return #1 after its accept edge.
    task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] dv);
        int guard;
        dividend = n;
        divisor  = dv;
        in_valid = 1'b1;
        sb.push_back(model(n, dv));
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b q=%h r=%h dbz=%b, want all 0", out_valid, quotient, remainder, div_by_zero);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
        end
    endtask

    task automatic test_known();
        logic [NW-1:0] tn [3] = '{31'h12345678, 31'h007F8101, 31'h007F8104};
        logic [DW-1:0] td [3] = '{16'h0001, 16'h8003, 16'h8003};
        logic [NW-1:0] tq [3] = '{31'h12345678, 31'h000000FF, 31'h000000FF};
        logic [DW-2:0] tr [3] = '{15'h0000, 15'h0000, 15'h0005};
        exp_t e;
        int cyc;
        for (int k = 0; k < 3; k++) begin
            send(tn[k], td[k]);
            wait_out(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc != e.lat) begin
                errors++;
                $display("FAIL known%0d_latency: got %0d want %0d", k, cyc, e.lat);
            end
            checks++;
            if (quotient !== tq[k] || remainder !== tr[k] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL known%0d_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=0", k, quotient, remainder, div_by_zero, tq[k], tr[k]);
            end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL known%0d_release: got ov=%b ir=%b want ov=0 ir=1", k, out_valid, in_ready);
            end
        end
`ifndef GF2DIV_EARLY_EXIT_EN
        checks++;
        if (model(31'h12345678, 16'h0001).lat != 32 || model(31'h007F8101, 16'h8003).lat != 17) begin
            errors++;
            $display("FAIL latency_table: got %0d/%0d want 32/17", model(31'h12345678, 16'h0001).lat, model(31'h007F8101, 16'h8003).lat);
        end
`endif
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        int cyc;
        send(31'h5A5A1234, 16'h0000);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d want 1", cyc);
        end
        checks++;
        if (div_by_zero !== 1'b1 || quotient !== '0 || remainder !== '0 || e.dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: got dbz=%b q=%h r=%h want dbz=1 q=0 r=0", div_by_zero, quotient, remainder);
        end
        release_out();
        send(31'h00000009, 16'h0003);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== 31'h7 || remainder !== 15'h0 || cyc != e.lat) begin
            errors++;
            $display("FAIL dbz_clear: got dbz=%b q=%h r=%h lat=%0d want dbz=0 q=7 r=0 lat=%0d", div_by_zero, quotient, remainder, cyc, e.lat);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        exp_t ea;
        exp_t eb;
        int cyc;
        send(31'h007F8104, 16'h8003);
        wait_out(cyc);
        ea = sb.pop_front();
        dividend = 31'h0000ABCD;
        divisor  = 16'h0011;
        in_valid = 1'b1;
        sb.push_back(model(31'h0000ABCD, 16'h0011));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== ea.q || remainder !== ea.r) begin
                errors++;
                $display("FAIL hold_c%0d: got ov=%b ir=%b q=%h r=%h want ov=1 ir=0 q=%h r=%h", c, out_valid, in_ready, quotient, remainder, ea.q, ea.r);
            end
        end
        release_out();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(cyc);
        eb = sb.pop_front();
        checks++;
        if (quotient !== eb.q || remainder !== eb.r || div_by_zero !== 1'b0 || cyc != eb.lat) begin
            errors++;
            $display("FAIL after_hold: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", quotient, remainder, cyc, eb.q, eb.r, eb.lat);
        end
        release_out();
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        int cyc;
        send(31'h12345678, 16'h0001);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(sb.pop_front());
        #1;
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got ov=%b q=%h r=%h dbz=%b ir=%b want 0/0/0/0/1", out_valid, quotient, remainder, div_by_zero, in_ready);
        end
        send(31'h007F8101, 16'h8003);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (quotient !== 31'h000000FF || remainder !== 15'h0 || cyc != e.lat) begin
            errors++;
            $display("FAIL midreset_next: got q=%h r=%h lat=%0d want q=ff r=0 lat=%0d", quotient, remainder, cyc, e.lat);
        end
        release_out();
    endtask

    task automatic test_random();
        exp_t e;
        int cyc;
        logic [NW-1:0] n;
        logic [DW-1:0] dv;
        logic [NW+DW-1:0] recon;
        int deg;
        for (int k = 0; k < 10; k++) begin
            n  = NW'($urandom);
            dv = DW'($urandom) >> $urandom_range(0, 15);
            if (dv == '0) dv = 16'h0001;
            deg = 0;
            for (int i = 0; i < DW; i++) if (dv[i]) deg = i;
            send(n, dv);
            wait_out(cyc);
            e = sb.pop_front();
            recon = clmul(quotient, dv) ^ (NW + DW)'(remainder);
            checks++;
            if (recon !== (NW + DW)'(n) || (deg < DW - 1 && (remainder >> deg) != '0)) begin
                errors++;
                $display("FAIL rand%0d_identity: n=%h d=%h got q=%h r=%h", k, n, dv, quotient, remainder);
            end
            checks++;
            if (quotient !== e.q || remainder !== e.r || cyc != e.lat) begin
                errors++;
                $display("FAIL rand%0d_model: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", k, quotient, remainder, cyc, e.q, e.r, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_early_exit();
        exp_t e;
        int cyc;
        send(31'h00008003, 16'h8003);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
`ifdef GF2DIV_EARLY_EXIT_EN
        if (quotient !== 31'h1 || remainder !== 15'h0 || cyc != 2) begin
            errors++;
            $display("FAIL early_exit: got q=%h r=%h lat=%0d want q=1 r=0 lat=2", quotient, remainder, cyc);
        end
`else
        if (quotient !== 31'h1 || remainder !== 15'h0 || cyc != 17) begin
            errors++;
            $display("FAIL early_exit: got q=%h r=%h lat=%0d want q=1 r=0 lat=17", quotient, remainder, cyc);
        end
`endif
        release_out();
    endtask

    initial begin
        test_reset();
        test_known();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_div();
        test_early_exit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
